// File: rtl/pc_pkg.sv
// Shared types for the program-counter unit: PC source encoding and next-PC priority.
package pc_pkg;

    typedef enum logic [2:0] {
        SEL_HOLD  = 3'd0,
        SEL_INC   = 3'd1,
        SEL_CALL  = 3'd2,
        SEL_RAS   = 3'd3,
        SEL_REDIR = 3'd4,
        SEL_TRAP  = 3'd5
    } pc_src_e;

    // Next-PC priority classes, highest first.
    typedef enum logic [1:0] {
        PRI_TRAP  = 2'd0,
        PRI_REDIR = 2'd1,
        PRI_HOLD  = 2'd2,
        PRI_FLOW  = 2'd3
    } pc_prio_e;

    function automatic pc_prio_e prio_sel(input logic trap, input logic redirect,
                                          input logic pcwrite);
        if (trap)     return PRI_TRAP;
        if (redirect) return PRI_REDIR;
        if (!pcwrite) return PRI_HOLD;
        return PRI_FLOW;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push/pop/replace/clear, exposes top entry and valid count.
module pc_ras #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       replace,
    input  logic                       clear,
    input  logic [XLEN-1:0]            wdata,
    output logic [XLEN-1:0]            top,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [XLEN-1:0] mem [DEPTH];
    logic [PW-1:0]   ptr_q, ptr_nxt, top_idx, wr_idx;
    logic [CW-1:0]   count_q, count_nxt;
    logic            wr_en;

    // ptr_q points at the next free slot; the top entry sits just below it.
    assign top_idx = ptr_q - PW'(1);
    assign top     = mem[top_idx];
    assign count   = count_q;

    always_comb begin
        ptr_nxt   = ptr_q;
        count_nxt = count_q;
        wr_en     = 1'b0;
        wr_idx    = ptr_q;
        if (clear) begin
            ptr_nxt   = '0;
            count_nxt = '0;
        end else if (replace && (count_q != '0)) begin
            wr_en  = 1'b1;
            wr_idx = top_idx;
        end else if (push || replace) begin
            // A full stack keeps its count; the oldest slot is overwritten.
            wr_en   = 1'b1;
            ptr_nxt = ptr_q + PW'(1);
            if (count_q != CW'(DEPTH)) count_nxt = count_q + CW'(1);
        end else if (pop && (count_q != '0)) begin
            ptr_nxt   = top_idx;
            count_nxt = count_q - CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_nxt;
            count_q <= count_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_idx] <= wdata;
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC selection (trap/redirect/stall/call/return/increment) and PC register.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     INC          = 4,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_pcwrite,
    input  logic                          i_redirect,
    input  logic [XLEN-1:0]               i_redirect_pc,
    input  logic                          i_trap,
    input  logic [XLEN-1:0]               i_trap_vec,
    input  logic                          i_call,
    input  logic [XLEN-1:0]               i_call_target,
    input  logic [XLEN-1:0]               i_link_addr,
    input  logic                          i_ret,
    output logic [XLEN-1:0]               o_pc,
    output logic [2:0]                    o_pc_src,
    output logic [$clog2(RAS_DEPTH):0]    o_ras_count,
    output logic                          o_ras_underflow
);

    localparam int unsigned     CW         = $clog2(RAS_DEPTH) + 1;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INC) - XLEN'(1));

    logic [XLEN-1:0] pc_q, pc_nxt, ras_top;
    pc_src_e         src_q, src_nxt;
    logic            uf_q, uf_nxt;
    logic            ras_push, ras_pop, ras_replace, ras_clear;
    logic [CW-1:0]   ras_count;

    function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0] t);
        return t & ALIGN_MASK;
    endfunction

    pc_ras #(.XLEN(XLEN), .DEPTH(RAS_DEPTH)) u_ras (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .push    (ras_push),
        .pop     (ras_pop),
        .replace (ras_replace),
        .clear   (ras_clear),
        .wdata   (i_link_addr),
        .top     (ras_top),
        .count   (ras_count)
    );

    // Next-PC selection and RAS control.
    always_comb begin
        pc_nxt      = pc_q + XLEN'(INC);
        src_nxt     = SEL_INC;
        uf_nxt      = 1'b0;
        ras_push    = 1'b0;
        ras_pop     = 1'b0;
        ras_replace = 1'b0;
        ras_clear   = 1'b0;
        unique case (prio_sel(i_trap, i_redirect, i_pcwrite))
            PRI_TRAP: begin
                pc_nxt    = align(i_trap_vec);
                src_nxt   = SEL_TRAP;
                ras_clear = 1'b1;
            end
            PRI_REDIR: begin
                pc_nxt  = align(i_redirect_pc);
                src_nxt = SEL_REDIR;
            end
            PRI_HOLD: begin
                pc_nxt  = pc_q;
                src_nxt = SEL_HOLD;
            end
            PRI_FLOW: begin
                if (i_call) begin
                    ras_replace = i_ret;
                    ras_push    = !i_ret;
                    pc_nxt      = align(i_call_target);
                    src_nxt     = SEL_CALL;
                end else if (i_ret) begin
                    if (ras_count != '0) begin
                        ras_pop = 1'b1;
                        pc_nxt  = align(ras_top);
                        src_nxt = SEL_RAS;
                    end else begin
                        uf_nxt = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q  <= RESET_VECTOR;
            src_q <= SEL_HOLD;
            uf_q  <= 1'b0;
        end else begin
            pc_q  <= pc_nxt;
            src_q <= src_nxt;
            uf_q  <= uf_nxt;
        end
    end

    assign o_pc            = pc_q;
    assign o_pc_src        = src_q;
    assign o_ras_count     = ras_count;
    assign o_ras_underflow = uf_q;

endmodule
